song_note_sequencer: RTL and testbench

//  Downstream consumer of the song FIFO (15-bit entries, synchronous-reset FIFO, 1-cycle read latency

---
 rtl/song_note_sequencer.sv | 143 ++++++++++++++
 tb/tb_song_note_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_note_sequencer.sv
// Song note sequencer: pops {note, duration} entries from the song FIFO, holds each note for its
// duration in beat ticks and scores the detected pitch. Optional macro SEMITONE_TOL_EN widens the match window to +/-1.
module song_note_sequencer #(
    parameter int NOTE_W = 7,
    parameter int DUR_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    tick,
    input  logic [NOTE_W+DUR_W-1:0] fifo_dout,
    input  logic                    fifo_valid,
    input  logic                    fifo_empty,
    input  logic [NOTE_W-1:0]       detected_note,
    input  logic                    detected_valid,
    output logic                    fifo_rd_en,
    output logic [NOTE_W-1:0]       target_note,
    output logic                    note_active,
    output logic [CNT_W-1:0]        hits,
    output logic [CNT_W-1:0]        ticks_total,
    output logic                    busy,
    output logic                    song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NOTE_W-1:0]  target_note_q, target_note_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic [CNT_W-1:0]   ticks_q, ticks_d;

    logic [NOTE_W-1:0]  entry_note;
    logic [DUR_W-1:0]   entry_dur;
    logic               pitch_match;

    assign entry_note = fifo_dout[NOTE_W+DUR_W-1:DUR_W];
    assign entry_dur  = fifo_dout[DUR_W-1:0];

`ifdef SEMITONE_TOL_EN
    // Absolute difference taken by ordering the operands, so target 1 vs detected 0 cannot underflow.
    logic [NOTE_W-1:0] note_diff;
    assign note_diff   = (detected_note >= target_note_q) ? (detected_note - target_note_q)
                                                          : (target_note_q - detected_note);
    assign pitch_match = (note_diff <= NOTE_W'(1));
`else
    assign pitch_match = (detected_note == target_note_q);
`endif

    always_comb begin
        state_d       = state_q;
        target_note_d = target_note_q;
        dur_cnt_d     = dur_cnt_q;
        hits_d        = hits_q;
        ticks_d       = ticks_q;
        fifo_rd_en    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    hits_d        = '0;
                    ticks_d       = '0;
                    target_note_d = '0;
                    state_d       = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fifo_empty) begin
                    target_note_d = '0;
                    state_d       = S_DONE;
                end else begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                // An all-zero entry marks the end of the song; a zero-length note is dropped.
                if (fifo_valid) begin
                    if (fifo_dout == '0) begin
                        target_note_d = '0;
                        state_d       = S_DONE;
                    end else if (entry_dur == '0) begin
                        state_d = S_FETCH;
                    end else begin
                        target_note_d = entry_note;
                        dur_cnt_d     = entry_dur;
                        state_d       = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (target_note_q != '0) begin
                        if (!(&ticks_q)) begin
                            ticks_d = ticks_q + CNT_W'(1);
                        end
                        if (detected_valid && pitch_match && !(&hits_q)) begin
                            hits_d = hits_q + CNT_W'(1);
                        end
                    end
                    dur_cnt_d = dur_cnt_q - DUR_W'(1);
                    if (dur_cnt_q <= DUR_W'(1)) begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            target_note_q <= '0;
            dur_cnt_q     <= '0;
            hits_q        <= '0;
            ticks_q       <= '0;
        end else begin
            state_q       <= state_d;
            target_note_q <= target_note_d;
            dur_cnt_q     <= dur_cnt_d;
            hits_q        <= hits_d;
            ticks_q       <= ticks_d;
        end
    end

    assign target_note = target_note_q;
    assign note_active = (state_q == S_PLAY) && (target_note_q != '0);
    assign hits        = hits_q;
    assign ticks_total = ticks_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign song_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_song_note_sequencer.sv
// Testbench for song_note_sequencer: directed song scenarios plus randomized songs scored
// against a per-tick note timeline derived from the song list.
module tb_song_note_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic [14:0] fifo_dout = '0;
    logic        fifo_valid = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [6:0]  detected_note = '0;
    logic        detected_valid = 1'b0;
    logic        fifo_rd_en;
    logic [6:0]  target_note;
    logic        note_active;
    logic [15:0] hits;
    logic [15:0] ticks_total;
    logic        busy;
    logic        song_done;

    int checks = 0;
    int failures = 0;
    logic [14:0] fifo_q[$];
    logic [14:0] song_q[$];
    int rd_while_empty = 0;
    int back_to_back = 0;
    int saw_62 = 0;
    logic prev_rd = 1'b0;

    always #5 clk = ~clk;

    song_note_sequencer #(.NOTE_W(7), .DUR_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick),
        .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .fifo_empty(fifo_empty),
        .detected_note(detected_note), .detected_valid(detected_valid),
        .fifo_rd_en(fifo_rd_en), .target_note(target_note), .note_active(note_active),
        .hits(hits), .ticks_total(ticks_total), .busy(busy), .song_done(song_done)
    );

    // Song FIFO with one-cycle read latency.
    always @(posedge clk) begin
        fifo_valid <= 1'b0;
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_dout  <= fifo_q.pop_front();
            fifo_valid <= 1'b1;
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (fifo_rd_en && fifo_empty) rd_while_empty++;
        if (fifo_rd_en && prev_rd) back_to_back++;
        prev_rd = fifo_rd_en;
        if (target_note == 7'd62) saw_62++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit modelMatch(input int det, input int tgt);
`ifdef SEMITONE_TOL_EN
        return ((det - tgt) <= 1) && ((tgt - det) <= 1);
`else
        return det == tgt;
`endif
    endfunction

    // Plays song_q. det_mode 0 drives det_fixed every tick, 1 drives random near-misses.
    // Stops early (no end checks) after max_ticks ticks.
    task automatic applyStimulus(input string tag, input int det_mode, input int det_fixed,
                                 input int max_ticks);
        logic [6:0]  exp_note[$];
        logic [14:0] e;
        int consumed, exp_hits, exp_total, period, n_ticks;
        logic [6:0] dn;
        logic dv;

        consumed = song_q.size();
        for (int i = 0; i < song_q.size(); i++) begin
            e = song_q[i];
            if (e == 15'd0) begin
                consumed = i + 1;
                break;
            end
            for (int k = 0; k < int'(e[7:0]); k++) exp_note.push_back(e[14:8]);
        end

        fifo_q.delete();
        foreach (song_q[i]) fifo_q.push_back(song_q[i]);
        stepCycles(2);

        start = 1'b1;
        stepCycles(1);
        start = 1'b0;
        checkOutput({tag, "_rd_en_after_start"}, fifo_rd_en, 1);
        checkOutput({tag, "_busy"}, busy, 1);
        checkOutput({tag, "_hits_cleared"}, hits, 0);
        checkOutput({tag, "_ticks_cleared"}, ticks_total, 0);
        stepCycles(1);
        checkOutput({tag, "_rd_en_single"}, fifo_rd_en, 0);

        exp_hits = 0;
        exp_total = 0;
        n_ticks = exp_note.size();
        if (max_ticks < n_ticks) n_ticks = max_ticks;

        for (int k = 0; k < n_ticks; k++) begin
            period = $urandom_range(8, 12);
            stepCycles(period - 1);
            if (det_mode == 0) begin
                dn = 7'(det_fixed);
                dv = 1'b1;
            end else begin
                case ($urandom_range(0, 3))
                    0: dn = exp_note[k];
                    1: dn = exp_note[k] + 7'd1;
                    2: dn = exp_note[k] - 7'd1;
                    default: dn = 7'($urandom_range(0, 127));
                endcase
                dv = ($urandom_range(0, 3) != 0);
            end
            tick = 1'b1;
            detected_note = dn;
            detected_valid = dv;
            checkOutput({tag, "_target_note"}, target_note, exp_note[k]);
            checkOutput({tag, "_note_active"}, note_active, (exp_note[k] != 0));
            stepCycles(1);
            tick = 1'b0;
            detected_valid = 1'b0;
            if (exp_note[k] != 0) begin
                exp_total++;
                if (dv && modelMatch(int'(dn), int'(exp_note[k]))) exp_hits++;
            end
            checkOutput({tag, "_hits_run"}, hits, exp_hits);
            checkOutput({tag, "_ticks_run"}, ticks_total, exp_total);
        end

        if (n_ticks < exp_note.size()) return;

        for (int w = 0; w < 30 && !song_done; w++) stepCycles(1);
        checkOutput({tag, "_song_done"}, song_done, 1);
        checkOutput({tag, "_busy_end"}, busy, 0);
        checkOutput({tag, "_target_end"}, target_note, 0);
        checkOutput({tag, "_active_end"}, note_active, 0);
        checkOutput({tag, "_hits_end"}, hits, exp_hits);
        checkOutput({tag, "_ticks_end"}, ticks_total, exp_total);
        checkOutput({tag, "_fifo_left"}, fifo_q.size(), song_q.size() - consumed);

        for (int k = 0; k < 2; k++) begin
            stepCycles(9);
            tick = 1'b1;
            detected_note = exp_note[0];
            detected_valid = 1'b1;
            stepCycles(1);
            tick = 1'b0;
            detected_valid = 1'b0;
        end
        checkOutput({tag, "_hits_hold"}, hits, exp_hits);
        checkOutput({tag, "_ticks_hold"}, ticks_total, exp_total);
        checkOutput({tag, "_done_hold"}, song_done, 1);
    endtask

    initial begin
        int n, nt;
        bit prev_disc;

        rst = 1'b1;
        stepCycles(3);
        checkOutput("reset_target", target_note, 0);
        checkOutput("reset_active", note_active, 0);
        checkOutput("reset_hits", hits, 0);
        checkOutput("reset_ticks", ticks_total, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", song_done, 0);
        checkOutput("reset_rd_en", fifo_rd_en, 0);
        rst = 1'b0;
        stepCycles(1);

        song_q = '{{7'd60, 8'd3}, 15'd0};
        applyStimulus("t1", 0, 60, 1000);
        checkOutput("t1_hits_const", hits, 3);
        checkOutput("t1_ticks_const", ticks_total, 3);

        song_q = '{{7'd60, 8'd2}, {7'd0, 8'd2}, 15'd0};
        applyStimulus("t2", 0, 60, 1000);
        checkOutput("t2_hits_const", hits, 2);
        checkOutput("t2_ticks_const", ticks_total, 2);

        fifo_q.delete();
        stepCycles(2);
        start = 1'b1;
        stepCycles(1);
        start = 1'b0;
        checkOutput("t3_no_rd_en", fifo_rd_en, 0);
        stepCycles(1);
        checkOutput("t3_done", song_done, 1);
        checkOutput("t3_hits", hits, 0);
        checkOutput("t3_ticks", ticks_total, 0);

        song_q = '{{7'd62, 8'd0}, {7'd64, 8'd1}, 15'd0};
        applyStimulus("t4", 1, 0, 1000);
        checkOutput("t4_never_62", saw_62, 0);
        checkOutput("t4_ticks_const", ticks_total, 1);

        song_q = '{{7'd60, 8'd4}, 15'd0};
        applyStimulus("t5", 0, 61, 1000);
`ifdef SEMITONE_TOL_EN
        checkOutput("t5_hits_const", hits, 4);
`else
        checkOutput("t5_hits_const", hits, 0);
`endif

        song_q = '{{7'd60, 8'd10}, 15'd0};
        applyStimulus("t6", 0, 60, 3);
        stepCycles(3);
        rst = 1'b1;
        stepCycles(1);
        checkOutput("t6_rst_target", target_note, 0);
        checkOutput("t6_rst_active", note_active, 0);
        checkOutput("t6_rst_hits", hits, 0);
        checkOutput("t6_rst_ticks", ticks_total, 0);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_done", song_done, 0);
        rst = 1'b0;
        stepCycles(1);
        song_q = '{{7'd64, 8'd2}, 15'd0};
        applyStimulus("t6_restart", 0, 64, 1000);

        for (int s = 0; s < 10; s++) begin
            song_q.delete();
            prev_disc = 1'b0;
            n = $urandom_range(2, 6);
            for (int i = 0; i < n; i++) begin
                if (!prev_disc && $urandom_range(0, 4) == 0) begin
                    song_q.push_back({7'($urandom_range(1, 127)), 8'd0});
                    prev_disc = 1'b1;
                end else begin
                    nt = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127);
                    song_q.push_back({7'(nt), 8'($urandom_range(1, 4))});
                    prev_disc = 1'b0;
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                song_q.push_back(15'd0);
                song_q.push_back({7'd99, 8'd5});
            end
            applyStimulus($sformatf("rand%0d", s), 1, 0, 1000);
        end

        checkOutput("rd_while_empty", rd_while_empty, 0);
        checkOutput("rd_back_to_back", back_to_back, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
